// File: rtl/conv_pkg.sv
// conv_pkg: sizing, MAC timing and FSM encoding shared by the convolution
// MAC sequencer and its kernel weight register file.
package conv_pkg;

  localparam int DATA_WIDTH  = 16;                 // signed pixel / weight width
  localparam int K           = 3;                  // kernel side
  localparam int ACC_WIDTH   = 2*DATA_WIDTH + 1;   // MAC accumulator / result width
  localparam int TAPS        = K*K;
  localparam int MAC_LATENCY = 3;                  // pixel/weight in cycle n -> result in n+3
  localparam int TAP_W       = $clog2(TAPS);
  localparam int ADDR_W      = $clog2(TAPS + 1);   // weights 0..TAPS-1, bias at TAPS

  // After the last tap's accumulator cycle the result still needs this many
  // cycles before it shows up on mac_result.
  localparam int DRAIN_CYCLES = MAC_LATENCY - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

endpackage

// File: rtl/kernel_weight_regs.sv
// kernel_weight_regs: TAPS signed weights plus one full-width bias.
// Synchronous write, asynchronous read of one weight by tap index.
//   clk, rst   clock, synchronous active-high reset (clears every entry)
//   we         write strobe (caller gates it to the idle state)
//   addr       0..TAPS-1 selects a weight, TAPS selects the bias
//   wdata      write data; weights keep the low DATA_WIDTH bits
//   rd_idx     tap index to read; out-of-range indices read as 0
//   rd_weight  weight[rd_idx]
//   bias       current bias
module kernel_weight_regs
  import conv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [ACC_WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0]     rd_idx,
  output logic [DATA_WIDTH-1:0] rd_weight,
  output logic [ACC_WIDTH-1:0]  bias
);

  logic [DATA_WIDTH-1:0] weight_arr [TAPS];
  logic [ACC_WIDTH-1:0]  bias_reg;

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_weight
      logic [DATA_WIDTH-1:0] weight_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          weight_reg <= '0;
        end else if (we && (addr == ADDR_W'(gi))) begin
          weight_reg <= wdata[DATA_WIDTH-1:0];
        end
      end

      assign weight_arr[gi] = weight_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      bias_reg <= '0;
    end else if (we && (addr == ADDR_W'(TAPS))) begin
      bias_reg <= wdata;
    end
  end

  assign rd_weight = (rd_idx < ADDR_W'(TAPS)) ? weight_arr[rd_idx] : '0;
  assign bias      = bias_reg;

endmodule

// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer: walks one external 3-stage signed MAC through a KxK
// window. A window is latched on the win handshake, one tap is issued every
// second cycle, the partial sum is chained back through mac_acc and the final
// sum is held on out_data until the consumer takes it.
//   clk, rst                      clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_wdata     weight/bias writes, honoured only in IDLE
//   cfg_busy                      1 while a window is in progress
//   win_valid/win_ready/win_data  flattened window input, tap 0 in the low bits
//   mac_pixel/mac_weight/mac_acc  operands to the MAC
//   mac_result                    MAC result (3 cycles after pixel/weight)
//   out_valid/out_ready/out_data  convolution sum output
module conv_mac_sequencer
  import conv_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [ADDR_W-1:0]          cfg_addr,
  input  logic [ACC_WIDTH-1:0]       cfg_wdata,
  output logic                       cfg_busy,
  input  logic                       win_valid,
  output logic                       win_ready,
  input  logic [TAPS*DATA_WIDTH-1:0] win_data,
  output logic [DATA_WIDTH-1:0]      mac_pixel,
  output logic [DATA_WIDTH-1:0]      mac_weight,
  output logic [ACC_WIDTH-1:0]       mac_acc,
  input  logic [ACC_WIDTH-1:0]       mac_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       out_data
);

  state_t                state_reg, state_next;
  logic [TAP_W-1:0]      tap_reg, tap_next;
  logic                  phase_reg, phase_next;   // 0: tap on the MAC, 1: accumulator cycle
  logic [1:0]            drain_reg, drain_next;
  logic [DATA_WIDTH-1:0] pixel_reg, pixel_next;
  logic [DATA_WIDTH-1:0] weight_reg, weight_next;
  logic                  out_valid_reg, out_valid_next;
  logic [ACC_WIDTH-1:0]  out_data_reg, out_data_next;

  logic [DATA_WIDTH-1:0] win_arr [TAPS];
  logic [TAP_W-1:0]      tap_inc;
  logic [ADDR_W-1:0]     rd_idx;
  logic [DATA_WIDTH-1:0] rd_weight;
  logic [DATA_WIDTH-1:0] weight0;
  logic [ACC_WIDTH-1:0]  bias;
  logic                  accept;
  logic                  cfg_write;

  assign win_ready = (state_reg == IDLE) && !rst;
  assign accept    = win_valid && win_ready;
  assign cfg_busy  = (state_reg != IDLE);
  assign cfg_write = cfg_we && (state_reg == IDLE);
  assign tap_inc   = tap_reg + TAP_W'(1);

  // Weight lookup runs one tap ahead so mac_weight can be registered.
  assign rd_idx = (state_reg == ISSUE) ? ADDR_W'(tap_inc) : '0;

  kernel_weight_regs u_weights (
    .clk       (clk),
    .rst       (rst),
    .we        (cfg_write),
    .addr      (cfg_addr),
    .wdata     (cfg_wdata),
    .rd_idx    (rd_idx),
    .rd_weight (rd_weight),
    .bias      (bias)
  );

  // Tap 0 is issued straight from the handshake cycle, so a weight-0 write
  // landing in that same cycle has to be forwarded.
  assign weight0 = (cfg_write && (cfg_addr == '0)) ? cfg_wdata[DATA_WIDTH-1:0] : rd_weight;

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_win
      logic [DATA_WIDTH-1:0] pix_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          pix_reg <= '0;
        end else if (accept) begin
          pix_reg <= win_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      assign win_arr[gi] = pix_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      tap_reg       <= '0;
      phase_reg     <= 1'b0;
      drain_reg     <= '0;
      pixel_reg     <= '0;
      weight_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      tap_reg       <= tap_next;
      phase_reg     <= phase_next;
      drain_reg     <= drain_next;
      pixel_reg     <= pixel_next;
      weight_reg    <= weight_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    tap_next       = tap_reg;
    phase_next     = phase_reg;
    drain_next     = drain_reg;
    pixel_next     = '0;
    weight_next    = '0;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next  = ISSUE;
          tap_next    = '0;
          phase_next  = 1'b0;
          pixel_next  = win_data[DATA_WIDTH-1:0];
          weight_next = weight0;
        end
      end
      ISSUE: begin
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else begin
          phase_next = 1'b0;
          if (tap_reg == TAP_W'(TAPS-1)) begin
            state_next = DRAIN;
            drain_next = '0;
          end else begin
            tap_next    = tap_inc;
            pixel_next  = win_arr[tap_inc];
            weight_next = rd_weight;
          end
        end
      end
      DRAIN: begin
        if (drain_reg == 2'(DRAIN_CYCLES-1)) begin
          state_next     = OUTPUT;
          out_valid_next = 1'b1;
          out_data_next  = mac_result;
        end else begin
          drain_next = drain_reg + 2'd1;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_next     = IDLE;
          out_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The accumulator operand must meet the tap one cycle after it is issued,
  // which is exactly when the previous tap's result appears: feed it through
  // combinationally rather than registering it.
  always_comb begin
    mac_acc = '0;
    if ((state_reg == ISSUE) && phase_reg) begin
      mac_acc = (tap_reg == '0) ? bias : mac_result;
    end
  end

  assign mac_pixel  = pixel_reg;
  assign mac_weight = weight_reg;
  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;

endmodule
